fwd_mux_pipe: RTL and testbench
===============================

FWD_MUX_PIPE -- requirements
Module: fwd_mux_pipe

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, data width of every source and of the output.
REQ-002 The block SHALL have parameter NUM_IN, default 4, source count; legal range 2..16.
REQ-003 The block SHALL have parameter SEL_W, default 2, select width; SEL_W SHALL be at least clog2(NUM_IN).
REQ-004 The block SHALL have parameter ILLEGAL_HOLD, default 0; when 0, an illegal select loads zero, and when 1 it holds the previous out_data.
REQ-005 The block SHALL have port clk, input, 1 bit, the single clock; all state is updated on its rising edge.
REQ-006 The block SHALL have port rst_n, input, 1 bit, reset that is asynchronous and active-low.
REQ-007 The block SHALL have port in_data, input, NUM_IN*WIDTH bits, flattened sources; source k occupies bits [k*WIDTH +: WIDTH].
REQ-008 The block SHALL have port sel, input, SEL_W bits, source index.
REQ-009 The block SHALL have port in_valid, input, 1 bit, which qualifies sel and in_data.
REQ-010 The block SHALL have port stall, input, 1 bit, which freezes all outputs and counters.
REQ-011 The block SHALL have port flush, input, 1 bit, which kills the output stage.
REQ-012 The block SHALL have port err_clr, input, 1 bit, which clears the error status.
REQ-013 The block SHALL have port out_data, output, WIDTH bits, the registered selected source.
REQ-014 The block SHALL have port out_valid, output, 1 bit, which qualifies out_data.
REQ-015 The block SHALL have port sel_err, output, 1 bit, a sticky flag for an illegal select.
REQ-016 The block SHALL have port err_cnt, output, 8 bits, a saturating count of illegal selects.

Function
REQ-017 The block SHALL register out_data and out_valid with one-cycle latency from an accepted input, with no combinational path from inputs to outputs.
REQ-018 The block SHALL apply this priority each edge: flush, then stall, then normal update.
REQ-019 On flush, the block SHALL set out_valid to 0 and out_data to 0, leave sel_err and err_cnt unchanged, and ignore in_valid in that cycle.
REQ-020 On stall with no flush, the block SHALL hold out_data, out_valid, sel_err and err_cnt, and SHALL NOT count an illegal select.
REQ-021 On a normal update with in_valid=1 and sel<NUM_IN, the block SHALL load in_data source sel into out_data and set out_valid to 1.
REQ-022 On a normal update with in_valid=1 and sel>=NUM_IN, the block SHALL set out_valid to 1, load out_data with 0 when ILLEGAL_HOLD=0 or hold it when ILLEGAL_HOLD=1, set sel_err, and increment err_cnt.
REQ-023 On a normal update with in_valid=0, the block SHALL set out_valid to 0, hold out_data, and SHALL NOT evaluate sel.
REQ-024 err_cnt SHALL saturate at 255 and SHALL NOT wrap.
REQ-025 err_clr SHALL clear sel_err and err_cnt on the next edge, independent of stall but not of flush ordering.
REQ-026 When err_clr coincides with a counted illegal select, the block SHALL set sel_err to 1 and err_cnt to 1 (set wins).
REQ-027 Every combination of X-free inputs SHALL produce defined outputs, and no latch SHALL be inferred.

Reset
REQ-028 When rst_n=0, the block SHALL immediately set out_data=0, out_valid=0, sel_err=0 and err_cnt=0, regardless of clk.
REQ-029 Reset asserted mid-stall or mid-flush SHALL override both.
REQ-030 The first edge after rst_n deasserts SHALL perform a normal update.

Verification
REQ-031 With NUM_IN=4 and sources 0x11111111, 0x22222222, 0x33333333, 0x44444444, driving in_valid=1 with sel=0,1,2,3 on consecutive cycles -> out_data SHALL be 0x11111111..0x44444444 one cycle later, with out_valid=1 throughout.
REQ-032 With out_data=0x22222222, stall=1 for 3 cycles while sel and data change -> out_data SHALL remain 0x22222222, out_valid SHALL remain unchanged, and err_cnt SHALL remain unchanged.
REQ-033 With NUM_IN=3, SEL_W=2, sel=3 and in_valid=1 -> with ILLEGAL_HOLD=0, out_data SHALL be 0, and with ILLEGAL_HOLD=1 it SHALL hold; in both cases sel_err=1 and err_cnt=1.
REQ-034 With 300 consecutive illegal selects -> err_cnt SHALL be 255, and err_clr together with an illegal select SHALL give err_cnt=1 and sel_err=1.
REQ-035 With flush=1 and stall=1 together and in_valid=1 -> out_valid SHALL be 0 and out_data SHALL be 0.
REQ-036 Asserting rst_n=0 asynchronously between edges while out_valid=1 -> all outputs SHALL be 0 before the next clk edge.

Source files
------------

// File: rtl/fwd_mux_pipe.sv
// Registered NUM_IN:1 forwarding mux with flush/stall pipeline control
// and sticky, saturating tracking of out-of-range select values.
module fwd_mux_pipe #(
    parameter int WIDTH        = 32,
    parameter int NUM_IN       = 4,
    parameter int SEL_W        = 2,
    parameter int ILLEGAL_HOLD = 0
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NUM_IN*WIDTH-1:0] in_data,
    input  logic [SEL_W-1:0]        sel,
    input  logic                    in_valid,
    input  logic                    stall,
    input  logic                    flush,
    input  logic                    err_clr,
    output logic [WIDTH-1:0]        out_data,
    output logic                    out_valid,
    output logic                    sel_err,
    output logic [7:0]              err_cnt
);

    logic [WIDTH-1:0] outData_q, outData_d;
    logic             outValid_q, outValid_d;
    logic             selErr_q, selErr_d;
    logic [7:0]       errCnt_q, errCnt_d;

    logic [WIDTH-1:0] selData;
    logic             selLegal;
    logic             normalUpdate;
    logic             countIllegal;

    always_comb begin
        selData  = '0;
        selLegal = 1'b0;
        for (int k = 0; k < NUM_IN; k++) begin
            if (sel == SEL_W'(k)) begin
                selData  = in_data[k*WIDTH +: WIDTH];
                selLegal = 1'b1;
            end
        end
    end

    assign normalUpdate = !flush && !stall;
    assign countIllegal = normalUpdate && in_valid && !selLegal;

    // Flush wins over stall; err_clr acts under stall but is masked by flush.
    always_comb begin
        outData_d  = outData_q;
        outValid_d = outValid_q;
        selErr_d   = selErr_q;
        errCnt_d   = errCnt_q;

        if (flush) begin
            outData_d  = '0;
            outValid_d = 1'b0;
        end else if (normalUpdate) begin
            outValid_d = in_valid;
            if (in_valid && selLegal) begin
                outData_d = selData;
            end else if (in_valid && (ILLEGAL_HOLD == 0)) begin
                outData_d = '0;
            end
        end

        if (countIllegal) begin
            selErr_d = 1'b1;
            if (err_clr) begin
                errCnt_d = 8'd1;
            end else if (errCnt_q != 8'hFF) begin
                errCnt_d = errCnt_q + 8'd1;
            end
        end else if (err_clr && !flush) begin
            selErr_d = 1'b0;
            errCnt_d = 8'd0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            outData_q  <= '0;
            outValid_q <= 1'b0;
            selErr_q   <= 1'b0;
            errCnt_q   <= 8'd0;
        end else begin
            outData_q  <= outData_d;
            outValid_q <= outValid_d;
            selErr_q   <= selErr_d;
            errCnt_q   <= errCnt_d;
        end
    end

    assign out_data  = outData_q;
    assign out_valid = outValid_q;
    assign sel_err   = selErr_q;
    assign err_cnt   = errCnt_q;

endmodule

// File: tb/tb_fwd_mux_pipe.sv
// Self-checking bench: two fwd_mux_pipe configurations against a behavioural model
// (dut 0: NUM_IN=4 SEL_W=3 zero-on-illegal, dut 1: NUM_IN=3 SEL_W=2 hold-on-illegal).
module tb_fwd_mux_pipe;

    logic         clk;
    logic         rst_n;
    logic [127:0] inData;
    logic [2:0]   selIn;
    logic         inValid;
    logic         stall;
    logic         flush;
    logic         errClr;

    logic [31:0]  outData [2];
    logic         outValid [2];
    logic         selErr [2];
    logic [7:0]   errCnt [2];

    logic [31:0]  mData [2];
    logic         mValid [2];
    logic         mErr [2];
    logic [7:0]   mCnt [2];

    int checks = 0;
    int errors = 0;
    bit compareOn = 1'b0;

    fwd_mux_pipe #(.WIDTH(32), .NUM_IN(4), .SEL_W(3), .ILLEGAL_HOLD(0)) dutA (
        .clk(clk), .rst_n(rst_n), .in_data(inData), .sel(selIn),
        .in_valid(inValid), .stall(stall), .flush(flush), .err_clr(errClr),
        .out_data(outData[0]), .out_valid(outValid[0]), .sel_err(selErr[0]), .err_cnt(errCnt[0])
    );

    fwd_mux_pipe #(.WIDTH(32), .NUM_IN(3), .SEL_W(2), .ILLEGAL_HOLD(1)) dutB (
        .clk(clk), .rst_n(rst_n), .in_data(inData[95:0]), .sel(selIn[1:0]),
        .in_valid(inValid), .stall(stall), .flush(flush), .err_clr(errClr),
        .out_data(outData[1]), .out_valid(outValid[1]), .sel_err(selErr[1]), .err_cnt(errCnt[1])
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference behaviour for one configuration, straight from the priority rules.
    task automatic modelStep(input int d);
        int  s;
        int  n;
        bit  hold;
        bit  illegal;
        s       = (d == 0) ? int'(selIn) : int'(selIn[1:0]);
        n       = (d == 0) ? 4 : 3;
        hold    = (d == 1);
        illegal = inValid && (s >= n);
        if (flush) begin
            mData[d]  = 32'd0;
            mValid[d] = 1'b0;
        end else if (stall) begin
            if (errClr) begin
                mErr[d] = 1'b0;
                mCnt[d] = 8'd0;
            end
        end else begin
            mValid[d] = inValid;
            if (inValid && !illegal) mData[d] = 32'(inData >> (s * 32));
            if (illegal && !hold)    mData[d] = 32'd0;
            if (illegal) begin
                mErr[d] = 1'b1;
                mCnt[d] = errClr ? 8'd1 : ((mCnt[d] == 8'd255) ? 8'd255 : mCnt[d] + 8'd1);
            end else if (errClr) begin
                mErr[d] = 1'b0;
                mCnt[d] = 8'd0;
            end
        end
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int d = 0; d < 2; d++) begin
                mData[d] = 32'd0; mValid[d] = 1'b0; mErr[d] = 1'b0; mCnt[d] = 8'd0;
            end
        end else begin
            for (int d = 0; d < 2; d++) modelStep(d);
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", name, actual, expected, $time);
        end
    endtask

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (compareOn) begin
                for (int d = 0; d < 2; d++) begin
                    checkOutput($sformatf("model out_data dut%0d", d), outData[d], mData[d]);
                    checkOutput($sformatf("model out_valid dut%0d", d), 32'(outValid[d]), 32'(mValid[d]));
                    checkOutput($sformatf("model sel_err dut%0d", d), 32'(selErr[d]), 32'(mErr[d]));
                    checkOutput($sformatf("model err_cnt dut%0d", d), 32'(errCnt[d]), 32'(mCnt[d]));
                end
            end
        end
    end

    task automatic applyStimulus(input bit v, input logic [2:0] s, input bit st, input bit fl, input bit clr);
        @(negedge clk);
        inValid = v;
        selIn   = s;
        stall   = st;
        flush   = fl;
        errClr  = clr;
        @(posedge clk);
        #2;
    endtask

    initial begin
        rst_n   = 1'b0;
        inData  = {32'h44444444, 32'h33333333, 32'h22222222, 32'h11111111};
        selIn   = 3'd0;
        inValid = 1'b0;
        stall   = 1'b0;
        flush   = 1'b0;
        errClr  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        for (int d = 0; d < 2; d++) begin
            checkOutput("reset out_data", outData[d], 32'd0);
            checkOutput("reset out_valid", 32'(outValid[d]), 32'd0);
            checkOutput("reset err_cnt", 32'(errCnt[d]), 32'd0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        compareOn = 1'b1;

        // Illegal select: zero versus hold
        applyStimulus(1, 3'd1, 0, 0, 0);
        applyStimulus(1, 3'd7, 0, 0, 0);
        checkOutput("illegal zero dataA", outData[0], 32'd0);
        checkOutput("illegal hold dataB", outData[1], 32'h22222222);
        checkOutput("illegal validA", 32'(outValid[0]), 32'd1);
        checkOutput("illegal errA", 32'(selErr[0]), 32'd1);
        checkOutput("illegal cntA", 32'(errCnt[0]), 32'd1);
        checkOutput("illegal errB", 32'(selErr[1]), 32'd1);
        checkOutput("illegal cntB", 32'(errCnt[1]), 32'd1);
        applyStimulus(0, 3'd0, 0, 0, 1);
        checkOutput("clr cntA", 32'(errCnt[0]), 32'd0);
        checkOutput("clr errA", 32'(selErr[0]), 32'd0);
        checkOutput("invalid holds dataB", outData[1], 32'h22222222);

        // Back-to-back selects 0..3
        for (int k = 0; k < 4; k++) begin
            applyStimulus(1, 3'(k), 0, 0, 0);
            checkOutput($sformatf("seq data sel%0d", k), outData[0], {4{4'(k + 1), 4'(k + 1)}});
            checkOutput($sformatf("seq valid sel%0d", k), 32'(outValid[0]), 32'd1);
        end

        // Stall freezes everything while inputs churn
        applyStimulus(1, 3'd1, 0, 0, 1);
        for (int c = 0; c < 3; c++) begin
            inData = {$urandom, $urandom, $urandom, $urandom};
            applyStimulus(1, 3'd7, 1, 0, 0);
            checkOutput("stall dataA", outData[0], 32'h22222222);
            checkOutput("stall validA", 32'(outValid[0]), 32'd1);
            checkOutput("stall cntA", 32'(errCnt[0]), 32'd0);
        end

        // Saturation, then clear coinciding with an illegal select
        repeat (300) applyStimulus(1, 3'd7, 0, 0, 0);
        checkOutput("sat cntA", 32'(errCnt[0]), 32'd255);
        checkOutput("sat cntB", 32'(errCnt[1]), 32'd255);
        applyStimulus(1, 3'd7, 0, 0, 1);
        checkOutput("clr+illegal cntA", 32'(errCnt[0]), 32'd1);
        checkOutput("clr+illegal errA", 32'(selErr[0]), 32'd1);
        checkOutput("clr+illegal cntB", 32'(errCnt[1]), 32'd1);

        // Flush beats stall
        applyStimulus(1, 3'd0, 0, 0, 0);
        applyStimulus(1, 3'd0, 1, 1, 0);
        checkOutput("flush validA", 32'(outValid[0]), 32'd0);
        checkOutput("flush dataA", outData[0], 32'd0);
        checkOutput("flush dataB", outData[1], 32'd0);
        checkOutput("flush keeps cntA", 32'(errCnt[0]), 32'd1);

        // Asynchronous reset between edges, with stall and flush raised
        inData = {32'h44444444, 32'h33333333, 32'h22222222, 32'h11111111};
        applyStimulus(1, 3'd0, 0, 0, 0);
        checkOutput("pre-reset validA", 32'(outValid[0]), 32'd1);
        stall = 1'b1;
        flush = 1'b1;
        #1;
        rst_n = 1'b0;
        #1;
        checkOutput("async dataA", outData[0], 32'd0);
        checkOutput("async validA", 32'(outValid[0]), 32'd0);
        checkOutput("async errA", 32'(selErr[0]), 32'd0);
        checkOutput("async cntA", 32'(errCnt[0]), 32'd0);
        @(negedge clk);
        rst_n   = 1'b1;
        stall   = 1'b0;
        flush   = 1'b0;
        inValid = 1'b1;
        selIn   = 3'd2;
        @(posedge clk);
        #2;
        checkOutput("first edge dataA", outData[0], 32'h33333333);
        checkOutput("first edge validA", 32'(outValid[0]), 32'd1);

        // Randomized traffic against the model
        for (int i = 0; i < 2000; i++) begin
            inData = {$urandom, $urandom, $urandom, $urandom};
            applyStimulus($urandom_range(0, 9) < 7, 3'($urandom_range(0, 7)),
                          $urandom_range(0, 9) < 2, $urandom_range(0, 19) == 0,
                          $urandom_range(0, 9) == 0);
        end

        compareOn = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
